led_mmio_peripheral: RTL and testbench
======================================

// Module: led_mmio_peripheral
// PURPOSE
//   Memory-mapped LED output port sitting directly downstream of the processor core's data-memory
//   bus inside core_top. Decodes core load/store requests in a fixed address window and holds the
//   LED state register that drives the board LEDs. Provides set, clear and toggle write ports, plus
//   a saturating store counter for firmware debug. Acknowledges every in-window request one cycle
//   after it is sampled.
// PARAMETERS
//   BASE_ADDR   32'h0000_1000  byte address of register window (4 KiB aligned)
//   LED_WIDTH   8              number of LED outputs (1..32)
//   RESET_LEDS  8'h00          LED register value applied on reset
// PORTS
//   clk        in   1          core clock, all state on rising edge
//   rst_n      in   1          asynchronous active-low reset
//   bus_rd     in   1          load request, single-cycle strobe
//   bus_wr     in   1          store request, single-cycle strobe
//   bus_addr   in   32         byte address; bits [1:0] ignored
//   bus_wdata  in   32         store data; only [LED_WIDTH-1:0] used
//   bus_rdata  out  32         load data, valid only while bus_ack=1
//   bus_ack    out  1          one-cycle acknowledge for in-window request
//   leds       out  LED_WIDTH  LED drive, active-high, registered
// BEHAVIOUR
//   Select: sel = (bus_rd|bus_wr) && bus_addr[31:12]==BASE_ADDR[31:12].
//     Out-of-window requests are ignored entirely: no ack and no state change.
//   Register map (offset = bus_addr[11:0]):
//     0x00 LED_DATA: RW.
//     0x04 LED_SET: W1S; LED |= wdata; reads 0.
//     0x08 LED_CLR: W1C; LED &= ~wdata; reads 0.
//     0x0C LED_TGL: LED ^= wdata; reads 0.
//     0x10 WR_CNT: RO; count of accepted stores, 16-bit, saturates at 16'hFFFF, zero-extended.
//     0x14 PWM_DUTY: see CONFIGURATION.
//     Other offsets: ack; read 0; write ignored.
//   Timing:
//     A request sampled at edge N updates leds and drives bus_ack=1 after edge N.
//     bus_rdata is registered and valid during that same cycle.
//     Latency 1, throughput 1 request per cycle; back-to-back requests give consecutive acks.
//   bus_rd and bus_wr both high: treated as a write; single ack; bus_rdata=0.
//   WR_CNT increments on every accepted store to any in-window offset, including unmapped ones.
//     It does not increment on writes to WR_CNT itself.
//   Read returns the LED value before any store in the same cycle (no bypass).
//   Writes use wdata[LED_WIDTH-1:0]; reads zero-extend to 32 bits.
//   Reset values (asynchronous, immediate):
//     leds=RESET_LEDS, bus_ack=0, bus_rdata=0, WR_CNT=0, PWM_DUTY=8'hFF, PWM counter=0.
//     Reset mid-request drops the pending ack; the request is lost and the core retries.
// CONFIGURATION
//   LED_PWM_EN defined:
//     8-bit free-running counter; PWM_DUTY register RW [7:0].
//     leds = led_reg & {LED_WIDTH{cnt < duty}}; duty 8'hFF = on 255/256 of cycles.
//     Output is registered and lags led_reg by 1 cycle extra.
//     LED_DATA readback returns led_reg, not the PWM'd value.
//   LED_PWM_EN undefined:
//     No counter is built; offset 0x14 behaves as an unmapped offset; leds = led_reg directly.
// STRUCTURE
//   Shared package (core_pkg): register offset constants (LED_OFS_DATA/SET/CLR/TGL/WRCNT/PWM),
//     BUS_AW=32, BUS_DW=32.
//   One sub-module: led_pwm_gen (counter + compare), instantiated only under LED_PWM_EN.
//   Decode, register file and ack pipeline stay in this module.
// TESTING
//   Clock period 2 ns; rst_n low for 5 ns, then high; LED_WIDTH=8, BASE_ADDR=0x1000.
//   Reset:
//     During and after reset -> leds=8'h00, bus_ack=0.
//     Assert rst_n=0 while a store is pending -> ack cleared, leds=00.
//   Store 0x000000A5 to 0x1000, then load 0x1000:
//     leds=A5 one cycle after the store; load ack with rdata=0x000000A5.
//   From LED=A5:
//     SET 0x0F @0x1004 -> AF.
//     CLR 0x03 @0x1008 -> AC.
//     TGL 0xFF @0x100C -> 53.
//     WR_CNT read -> 0x00000004.
//   Store 0x77 to 0x2000 (out of window) -> no ack, leds unchanged.
//   Store to 0x1100 (unmapped) -> ack, leds unchanged, WR_CNT +1.
//   Store 0x3C to 0x1000 with bus_rd=bus_wr=1:
//     single ack, rdata=0, leds=3C.
//   Back-to-back stores 0x01, 0x02, 0x04 on consecutive cycles:
//     three consecutive acks; leds follows 01, 02, 04.
//   With LED_PWM_EN: LED=FF, PWM_DUTY=0x40 -> leds high for exactly 64 of every 256 cycles.
//   With LED_PWM_EN: PWM_DUTY=0 -> leds=00 continuously.

Source files
------------

// File: rtl/led_mmio_peripheral_pkg.sv
// Shared definitions for the LED MMIO peripheral: bus widths, register
// offsets and the offset decoder used by the register file.
package led_mmio_peripheral_pkg;

   localparam int BUS_AW = 32;
   localparam int BUS_DW = 32;

   localparam logic [11:0] LED_OFS_DATA  = 12'h000;
   localparam logic [11:0] LED_OFS_SET   = 12'h004;
   localparam logic [11:0] LED_OFS_CLR   = 12'h008;
   localparam logic [11:0] LED_OFS_TGL   = 12'h00C;
   localparam logic [11:0] LED_OFS_WRCNT = 12'h010;
   localparam logic [11:0] LED_OFS_PWM   = 12'h014;

   typedef enum logic [2:0] {
      REG_DATA,
      REG_SET,
      REG_CLR,
      REG_TGL,
      REG_WRCNT,
      REG_PWM,
      REG_NONE
   } reg_sel_e;

   // Word offset (byte offset bits [11:2]) to register selector
   function automatic reg_sel_e decode_offset(input logic [9:0] word_ofs);
      logic [11:0] ofs;
      ofs = {word_ofs, 2'b00};
      case (ofs)
         LED_OFS_DATA:  return REG_DATA;
         LED_OFS_SET:   return REG_SET;
         LED_OFS_CLR:   return REG_CLR;
         LED_OFS_TGL:   return REG_TGL;
         LED_OFS_WRCNT: return REG_WRCNT;
         LED_OFS_PWM:   return REG_PWM;
         default:       return REG_NONE;
      endcase
   endfunction

endpackage

// File: rtl/led_mmio_peripheral_if.sv
// Core data-memory bus as seen by the LED peripheral.
// The core drives the request side (master), the peripheral answers (slave).
interface led_mmio_peripheral_if;
   import led_mmio_peripheral_pkg::*;

   logic              bus_rd;
   logic              bus_wr;
   logic [BUS_AW-1:0] bus_addr;
   logic [BUS_DW-1:0] bus_wdata;
   logic [BUS_DW-1:0] bus_rdata;
   logic              bus_ack;

   modport master (
      output bus_rd, bus_wr, bus_addr, bus_wdata,
      input  bus_rdata, bus_ack
   );

   modport slave (
      input  bus_rd, bus_wr, bus_addr, bus_wdata,
      output bus_rdata, bus_ack
   );

endinterface

// File: rtl/led_mmio_peripheral_pwm_gen.sv
// led_pwm_gen: 8-bit free-running counter and duty compare that gates the
// LED register onto the pins. Only built when LED_PWM_EN is defined.
// The gated output is registered, so the pins trail led_in by one cycle.
module led_pwm_gen #(
   parameter int                   LED_WIDTH  = 8,
   parameter logic [LED_WIDTH-1:0] RESET_LEDS = '0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [LED_WIDTH-1:0] led_in,
   input  logic [7:0]           duty,
   output logic [LED_WIDTH-1:0] leds
);

   logic [7:0] pwm_cnt;

   // Free-running PWM phase counter, wraps every 256 cycles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pwm_cnt <= 8'h00;
      else        pwm_cnt <= pwm_cnt + 8'h01;
   end

   // Gate LEDs on while the phase is below the duty value
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) leds <= RESET_LEDS;
      else        leds <= led_in & {LED_WIDTH{pwm_cnt < duty}};
   end

endmodule

// File: rtl/led_mmio_peripheral.sv
// Memory-mapped LED output port on the core data-memory bus.
// Registers: LED_DATA, LED_SET, LED_CLR, LED_TGL, WR_CNT and (optional) PWM_DUTY.
// Every in-window request is acknowledged one cycle after it is sampled.
// Optional feature macro: LED_PWM_EN (adds PWM dimming via led_pwm_gen).
module led_mmio_peripheral
   import led_mmio_peripheral_pkg::*;
#(
   parameter logic [31:0]          BASE_ADDR  = 32'h0000_1000,
   parameter int                   LED_WIDTH  = 8,
   parameter logic [LED_WIDTH-1:0] RESET_LEDS = '0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   led_mmio_peripheral_if.slave bus,
   output logic [LED_WIDTH-1:0] leds
);

   logic                 sel;
   logic                 is_wr;
   logic                 is_rd;
   reg_sel_e             reg_sel;
   logic [LED_WIDTH-1:0] wdata_led;
   logic [LED_WIDTH-1:0] led_reg;
   logic [LED_WIDTH-1:0] led_next;
   logic [15:0]          wr_cnt;
   logic [BUS_DW-1:0]    read_data;
   logic [BUS_DW-1:0]    rdata_q;
   logic                 ack_q;
   logic                 unused_bits;

   // Zero-extend an LED-width value onto the data bus
   function automatic logic [BUS_DW-1:0] led_to_bus(input logic [LED_WIDTH-1:0] v);
      logic [BUS_DW-1:0] r;
      r = '0;
      r[LED_WIDTH-1:0] = v;
      return r;
   endfunction

   // Saturating 16-bit increment for the store counter
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'h0001;
   endfunction

   // A simultaneous load and store is handled as a store only
   assign sel       = (bus.bus_rd | bus.bus_wr) &&
                      (bus.bus_addr[31:12] == BASE_ADDR[31:12]);
   assign is_wr     = bus.bus_wr;
   assign is_rd     = bus.bus_rd & ~bus.bus_wr;
   assign reg_sel   = decode_offset(bus.bus_addr[11:2]);
   assign wdata_led = bus.bus_wdata[LED_WIDTH-1:0];

   // Byte-lane bits and upper store data are don't-care
   assign unused_bits = ^{bus.bus_addr[1:0], bus.bus_wdata};

`ifdef LED_PWM_EN
   logic [7:0] pwm_duty;

   // PWM duty register, full on (255/256) out of reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                  pwm_duty <= 8'hFF;
      else if (sel && is_wr && reg_sel == REG_PWM) pwm_duty <= bus.bus_wdata[7:0];
   end

   led_pwm_gen #(
      .LED_WIDTH  (LED_WIDTH),
      .RESET_LEDS (RESET_LEDS)
   ) u_pwm (
      .clk    (clk),
      .rst_n  (rst_n),
      .led_in (led_reg),
      .duty   (pwm_duty),
      .leds   (leds)
   );
`else
   assign leds = led_reg;
`endif

   // Load data mux; LED_DATA returns the raw register, not the PWM output
   always_comb begin
      read_data = '0;
      case (reg_sel)
         REG_DATA:  read_data = led_to_bus(led_reg);
         REG_WRCNT: read_data = {16'h0000, wr_cnt};
`ifdef LED_PWM_EN
         REG_PWM:   read_data = {24'h000000, pwm_duty};
`endif
         default:   read_data = '0;
      endcase
   end

   // Next LED value for a store to one of the LED write ports
   always_comb begin
      led_next = led_reg;
      if (sel && is_wr) begin
         case (reg_sel)
            REG_DATA: led_next = wdata_led;
            REG_SET:  led_next = led_reg | wdata_led;
            REG_CLR:  led_next = led_reg & ~wdata_led;
            REG_TGL:  led_next = led_reg ^ wdata_led;
            default:  led_next = led_reg;
         endcase
      end
   end

   // LED register and store counter (stores to WR_CNT itself are not counted)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led_reg <= RESET_LEDS;
         wr_cnt  <= 16'h0000;
      end else begin
         led_reg <= led_next;
         if (sel && is_wr && reg_sel != REG_WRCNT) wr_cnt <= sat_inc16(wr_cnt);
      end
   end

   // Ack and registered load data, one cycle after the request is sampled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         ack_q   <= sel;
         rdata_q <= (sel && is_rd) ? read_data : '0;
      end
   end

   assign bus.bus_ack   = ack_q;
   assign bus.bus_rdata = rdata_q;

endmodule

// File: tb/tb_led_mmio_peripheral.sv
// Self-checking bench for led_mmio_peripheral (LED_WIDTH=8, BASE_ADDR=0x1000).
// Directed register-map scenarios followed by randomized traffic against a
// behavioural model of the register map. PWM checks run when LED_PWM_EN is defined.
`timescale 1ns/100ps
module tb_led_mmio_peripheral;

   logic       clk;
   logic       rst_n;
   logic [7:0] leds;
   int         checks;
   int         errors;

   // Reference state of the register map
   logic [7:0]  m_led;
   logic [15:0] m_cnt;
   logic [7:0]  m_duty;

   led_mmio_peripheral_if bus ();

   led_mmio_peripheral #(
      .BASE_ADDR  (32'h0000_1000),
      .LED_WIDTH  (8),
      .RESET_LEDS (8'h00)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave),
      .leds  (leds)
   );

   initial begin
      clk = 1'b0;
      forever #1 clk = ~clk;
   end

   function automatic logic [31:0] model_read(input logic [11:0] ofs);
      case (ofs)
         12'h000: return {24'h0, m_led};
         12'h010: return {16'h0, m_cnt};
`ifdef LED_PWM_EN
         12'h014: return {24'h0, m_duty};
`endif
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_write(input logic [11:0] ofs, input logic [31:0] wd);
      case (ofs)
         12'h000: m_led = wd[7:0];
         12'h004: m_led = m_led | wd[7:0];
         12'h008: m_led = m_led & ~wd[7:0];
         12'h00C: m_led = m_led ^ wd[7:0];
`ifdef LED_PWM_EN
         12'h014: m_duty = wd[7:0];
`endif
         default: ;
      endcase
      if (ofs != 12'h010 && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
   endtask

   task automatic model_reset();
      m_led  = 8'h00;
      m_cnt  = 16'h0;
      m_duty = 8'hFF;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present one request at a falling edge; check the response one cycle later
   task automatic step(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wd, input string tag);
      logic        exp_ack;
      logic [31:0] exp_rdata;
      logic [11:0] ofs;
      bus.bus_rd    = rd;
      bus.bus_wr    = wr;
      bus.bus_addr  = addr;
      bus.bus_wdata = wd;
      exp_ack   = (rd | wr) && (addr[31:12] == 20'h00001);
      ofs       = addr[11:0] & 12'hFFC;
      exp_rdata = 32'h0;
      if (exp_ack && rd && !wr) exp_rdata = model_read(ofs);
      if (exp_ack && wr) model_write(ofs, wd);
      @(negedge clk);
      check({tag, ".ack"}, {31'h0, bus.bus_ack}, {31'h0, exp_ack});
      check({tag, ".rdata"}, bus.bus_rdata, exp_rdata);
`ifndef LED_PWM_EN
      check({tag, ".leds"}, {24'h0, leds}, {24'h0, m_led});
`endif
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 32'h0, 32'h0, "idle");
   endtask

`ifdef LED_PWM_EN
   task automatic pwm_window(input string tag, input int exp_on);
      int on_cnt;
      int bad;
      on_cnt = 0;
      bad    = 0;
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         if (leds === 8'hFF) on_cnt++;
         else if (leds !== 8'h00) bad++;
      end
      check({tag, ".on_cycles"}, on_cnt, exp_on);
      check({tag, ".partial"}, bad, 0);
   endtask
`endif

   initial begin
      logic [11:0] ofs_tab [8];
      logic [31:0] addr;
      logic        rd;
      logic        wr;
      checks = 0;
      errors = 0;
      ofs_tab = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010, 12'h014, 12'h100, 12'h7FC};
      model_reset();
      bus.bus_rd    = 1'b0;
      bus.bus_wr    = 1'b0;
      bus.bus_addr  = 32'h0;
      bus.bus_wdata = 32'h0;
      rst_n = 1'b0;

      // Reset state, during and after reset
      @(negedge clk);
      check("rst_during.leds", {24'h0, leds}, 32'h0);
      check("rst_during.ack", {31'h0, bus.bus_ack}, 32'h0);
      #3 rst_n = 1'b1;
      @(negedge clk);
      check("rst_after.leds", {24'h0, leds}, 32'h0);
      check("rst_after.ack", {31'h0, bus.bus_ack}, 32'h0);

      // Store then load LED_DATA
      step(1'b0, 1'b1, 32'h0000_1000, 32'h0000_00A5, "st_data");
      step(1'b1, 1'b0, 32'h0000_1000, 32'h0, "ld_data");
      // SET / CLR / TGL from A5, then store count
      step(1'b0, 1'b1, 32'h0000_1004, 32'h0F, "set");
      check("set.value", {24'h0, m_led}, 32'hAF);
      step(1'b0, 1'b1, 32'h0000_1008, 32'h03, "clr");
      check("clr.value", {24'h0, m_led}, 32'hAC);
      step(1'b0, 1'b1, 32'h0000_100C, 32'hFF, "tgl");
      check("tgl.value", {24'h0, m_led}, 32'h53);
      step(1'b1, 1'b0, 32'h0000_1010, 32'h0, "ld_wrcnt");
      // Out-of-window store, unmapped store, write to WR_CNT, set/clear readback
      step(1'b0, 1'b1, 32'h0000_2000, 32'h77, "st_oow");
      step(1'b0, 1'b1, 32'h0000_1100, 32'hFF, "st_unmapped");
      step(1'b0, 1'b1, 32'h0000_1010, 32'h1234, "st_wrcnt");
      step(1'b1, 1'b0, 32'h0000_1010, 32'h0, "ld_wrcnt2");
      step(1'b1, 1'b0, 32'h0000_1004, 32'h0, "ld_set_zero");
      // Simultaneous load and store is a store
      step(1'b1, 1'b1, 32'h0000_1000, 32'h3C, "rdwr");
      // Back-to-back stores
      step(1'b0, 1'b1, 32'h0000_1000, 32'h01, "b2b0");
      step(1'b0, 1'b1, 32'h0000_1000, 32'h02, "b2b1");
      step(1'b0, 1'b1, 32'h0000_1000, 32'h04, "b2b2");
      // Byte-lane bits ignored, upper wdata ignored
      step(1'b0, 1'b1, 32'h0000_1003, 32'hFFFF_FF5A, "st_lane");
      idle();

      // Reset while a store is in flight
      bus.bus_rd    = 1'b0;
      bus.bus_wr    = 1'b1;
      bus.bus_addr  = 32'h0000_1000;
      bus.bus_wdata = 32'hAA;
      @(posedge clk);
      #0.4;
      rst_n = 1'b0;
      bus.bus_wr = 1'b0;
      #0.2;
      model_reset();
      check("rst_mid.ack", {31'h0, bus.bus_ack}, 32'h0);
      check("rst_mid.leds", {24'h0, leds}, 32'h0);
      #0.2 rst_n = 1'b1;
      @(negedge clk);
      step(1'b1, 1'b0, 32'h0000_1010, 32'h0, "rst_mid.wrcnt");

      // Randomized traffic
      for (int i = 0; i < 300; i++) begin
         rd = 1'($urandom_range(0, 1));
         wr = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 7) == 0) begin
            addr = $urandom;
            if (addr[31:12] == 20'h00001) addr[31] = 1'b1;
         end else begin
            addr = {20'h00001, ofs_tab[$urandom_range(0, 7)]};
            addr[1:0] = 2'($urandom_range(0, 3));
         end
         step(rd, wr, addr, $urandom, "rand");
      end

`ifdef LED_PWM_EN
      step(1'b0, 1'b1, 32'h0000_1000, 32'hFF, "pwm_led");
      step(1'b0, 1'b1, 32'h0000_1014, 32'h40, "pwm_duty40");
      step(1'b1, 1'b0, 32'h0000_1014, 32'h0, "pwm_rd_duty");
      repeat (4) idle();
      pwm_window("pwm40", 64);
      step(1'b0, 1'b1, 32'h0000_1014, 32'h00, "pwm_duty0");
      repeat (4) idle();
      pwm_window("pwm0", 0);
      step(1'b1, 1'b0, 32'h0000_1000, 32'h0, "pwm_rd_led");
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
